hazard_controller: RTL and testbench

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

---
 rtl/mips_pkg.sv | 26 ++
 rtl/hazard_controller_load_use_detect.sv | 21 ++
 rtl/hazard_controller.sv | 147 ++++++++++++++
 tb/tb_hazard_controller.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mips_pkg
// Shared state encoding and defaults for the pipeline hazard controller.
// Revision: 1.0
// ----------------------------------------------------------------------------
package mips_pkg;

   typedef enum logic [2:0] {
      RUN       = 3'd0,
      STEP_WAIT = 3'd1,
      STEP_GO   = 3'd2,
      DRAIN     = 3'd3,
      HALTED    = 3'd4
   } hc_state_t;

   localparam int DRAIN_CYCLES_DEFAULT = 3;
   localparam int REG_ADDR_W           = 5;

   // States in which the pipeline may issue (fetch/decode advances)
   function automatic logic is_issue_state(input hc_state_t s);
      return (s == RUN) || (s == STEP_GO);
   endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_controller_load_use_detect.sv
`default_nettype none
// ----------------------------------------------------------------------------
// load_use_detect
// Combinational load-use hazard compare between EX load and ID sources.
// Revision: 1.0
// ----------------------------------------------------------------------------
module load_use_detect
   import mips_pkg::*;
(
   input  logic                  mem_read,
   input  logic [REG_ADDR_W-1:0] ex_rt,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   output logic                  hazard
);

   // Register 0 is hard-wired, so a load into it never creates a dependency
   assign hazard = mem_read && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule
`default_nettype wire

// File: rtl/hazard_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hazard_controller
// Load-use stall, branch flush, halt drain and debug single-step control.
// Optional stall counter enabled with macro HAZARD_STALL_CNT_EN.
// Revision: 1.0
// ----------------------------------------------------------------------------
module hazard_controller
   import mips_pkg::*;
#(
   parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT
)
(
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_IDEX_MemRead,
   input  logic [REG_ADDR_W-1:0] i_IDEX_RegisterRt,
   input  logic [REG_ADDR_W-1:0] i_IFID_RegisterRs,
   input  logic [REG_ADDR_W-1:0] i_IFID_RegisterRt,
   input  logic                  i_branch_taken,
   input  logic                  i_halt_instr,
   input  logic                  i_step_mode,
   input  logic                  i_step,
   output logic                  o_PCWrite,
   output logic                  o_IFIDWrite,
   output logic                  o_IDEX_bubble,
   output logic                  o_IFID_flush,
   output logic                  o_halted,
   output logic [2:0]            o_state
`ifdef HAZARD_STALL_CNT_EN
   ,
   output logic [15:0]           o_stall_count
`endif
);

   localparam int               CNT_W     = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DRAIN_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   hc_state_t        state;
   logic [CNT_W-1:0] drain_cnt;
   logic             hazard;
   logic             issue;
   logic             halt_accept;

   load_use_detect u_load_use_detect (
      .mem_read (i_IDEX_MemRead),
      .ex_rt    (i_IDEX_RegisterRt),
      .id_rs    (i_IFID_RegisterRs),
      .id_rt    (i_IFID_RegisterRt),
      .hazard   (hazard)
   );

   assign issue       = is_issue_state(state);
   // A halt behind a taken branch is wrong-path; a halt behind a stall waits in ID
   assign halt_accept = issue && i_halt_instr && !hazard && !i_branch_taken;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state     <= RUN;
         drain_cnt <= '0;
      end else begin
         case (state)
            RUN: begin
               if (halt_accept) begin
                  state     <= DRAIN;
                  drain_cnt <= '0;
               end else if (i_step_mode) begin
                  state <= STEP_WAIT;
               end
            end
            STEP_WAIT: begin
               if (!i_step_mode)
                  state <= RUN;
               else if (i_step)
                  state <= STEP_GO;
            end
            STEP_GO: begin
               if (halt_accept) begin
                  state     <= DRAIN;
                  drain_cnt <= '0;
               end else if (i_step_mode) begin
                  state <= STEP_WAIT;
               end else begin
                  state <= RUN;
               end
            end
            DRAIN: begin
               if (drain_cnt == CNT_LAST)
                  state <= HALTED;
               else
                  drain_cnt <= drain_cnt + CNT_ONE;
            end
            HALTED: state <= HALTED;
            default: begin
               state     <= RUN;
               drain_cnt <= '0;
            end
         endcase
      end
   end

   always_comb begin
      o_PCWrite     = 1'b0;
      o_IFIDWrite   = 1'b0;
      o_IDEX_bubble = 1'b0;
      o_IFID_flush  = 1'b0;
      o_halted      = 1'b0;
      case (state)
         RUN, STEP_GO: begin
            if (hazard) begin
               o_IDEX_bubble = 1'b1;
            end else if (i_branch_taken) begin
               o_PCWrite    = 1'b1;
               o_IFIDWrite  = 1'b1;
               o_IFID_flush = 1'b1;
            end else if (!i_halt_instr) begin
               o_PCWrite   = 1'b1;
               o_IFIDWrite = 1'b1;
            end
         end
         DRAIN: o_IDEX_bubble = 1'b1;
         HALTED: begin
            o_IDEX_bubble = 1'b1;
            o_halted      = 1'b1;
         end
         default: o_IDEX_bubble = 1'b0;
      endcase
   end

   assign o_state = state;

`ifdef HAZARD_STALL_CNT_EN
   logic [15:0] stall_count;

   always_ff @(posedge i_clk) begin
      if (i_reset)
         stall_count <= '0;
      else if (issue && !o_PCWrite && (stall_count != 16'hFFFF))
         stall_count <= stall_count + 16'd1;
   end

   assign o_stall_count = stall_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_hazard_controller
// Directed, scoreboard-checked bench for hazard_controller.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_hazard_controller;

   localparam logic [2:0] S_RUN   = 3'd0;
   localparam logic [2:0] S_SW    = 3'd1;
   localparam logic [2:0] S_SG    = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_HALT  = 3'd4;

   typedef struct packed {
      logic       pc;
      logic       ifid;
      logic       bub;
      logic       flush;
      logic       halted;
      logic [2:0] st;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       memrd;
   logic [4:0] ex_rt;
   logic [4:0] id_rs;
   logic [4:0] id_rt;
   logic       br;
   logic       halt;
   logic       smode;
   logic       stp;
   logic       pc_write;
   logic       ifid_write;
   logic       bubble;
   logic       flush;
   logic       halted;
   logic [2:0] state;
`ifdef HAZARD_STALL_CNT_EN
   logic [15:0] stall_count;
`endif

   exp_t  exp_q[$];
   string tag_q[$];
   int    checks = 0;
   int    errors = 0;

   always #5 clk = ~clk;

   hazard_controller dut (
      .i_clk             (clk),
      .i_reset           (reset),
      .i_IDEX_MemRead    (memrd),
      .i_IDEX_RegisterRt (ex_rt),
      .i_IFID_RegisterRs (id_rs),
      .i_IFID_RegisterRt (id_rt),
      .i_branch_taken    (br),
      .i_halt_instr      (halt),
      .i_step_mode       (smode),
      .i_step            (stp),
      .o_PCWrite         (pc_write),
      .o_IFIDWrite       (ifid_write),
      .o_IDEX_bubble     (bubble),
      .o_IFID_flush      (flush),
      .o_halted          (halted),
      .o_state           (state)
`ifdef HAZARD_STALL_CNT_EN
      ,
      .o_stall_count     (stall_count)
`endif
   );

   task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic set_in(input logic m, input logic [4:0] ert, input logic [4:0] rs,
                         input logic [4:0] rt, input logic b, input logic h,
                         input logic sm, input logic s);
      memrd = m; ex_rt = ert; id_rs = rs; id_rt = rt;
      br = b; halt = h; smode = sm; stp = s;
   endtask

   // Push the expectation for this cycle, compare at the falling edge, advance
   task automatic cyc(input string tag, input logic pc, input logic ifid, input logic bub,
                      input logic fl, input logic hl, input logic [2:0] st);
      exp_t  e;
      string t;
      exp_q.push_back({pc, ifid, bub, fl, hl, st});
      tag_q.push_back(tag);
      @(negedge clk);
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check({t, ".PCWrite"},   {15'd0, pc_write},   {15'd0, e.pc});
      check({t, ".IFIDWrite"}, {15'd0, ifid_write}, {15'd0, e.ifid});
      check({t, ".bubble"},    {15'd0, bubble},     {15'd0, e.bub});
      check({t, ".flush"},     {15'd0, flush},      {15'd0, e.flush});
      check({t, ".halted"},    {15'd0, halted},     {15'd0, e.halted});
      check({t, ".state"},     {13'd0, state},      {13'd0, e.st});
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      cyc("reset_state", 1, 1, 0, 0, 0, S_RUN);

      // Load-use hazards and the register-0 exemption
      set_in(1, 5, 5, 0, 0, 0, 0, 0); cyc("hazard_rs",   0, 0, 1, 0, 0, S_RUN);
      set_in(1, 5, 1, 5, 0, 0, 0, 0); cyc("hazard_rt",   0, 0, 1, 0, 0, S_RUN);
      set_in(1, 0, 0, 0, 0, 0, 0, 0); cyc("rt_zero",     1, 1, 0, 0, 0, S_RUN);
      set_in(0, 5, 5, 0, 0, 0, 0, 0); cyc("no_memread",  1, 1, 0, 0, 0, S_RUN);
      set_in(0, 0, 0, 0, 1, 0, 0, 0); cyc("branch",      1, 1, 0, 1, 0, S_RUN);
      set_in(1, 6, 6, 0, 1, 0, 0, 0); cyc("hazard_over_branch", 0, 0, 1, 0, 0, S_RUN);

      // Halt on a taken branch is dropped
      set_in(0, 0, 0, 0, 1, 1, 0, 0); cyc("halt_branch", 1, 1, 0, 1, 0, S_RUN);
      set_in(0, 0, 0, 0, 0, 0, 0, 0); cyc("halt_branch_stay", 1, 1, 0, 0, 0, S_RUN);

      // Halt deferred by a hazard, then drained
      set_in(1, 3, 3, 0, 0, 1, 0, 0); cyc("halt_hazard", 0, 0, 1, 0, 0, S_RUN);
      set_in(0, 3, 3, 0, 0, 1, 0, 0); cyc("halt_accept", 0, 0, 0, 0, 0, S_RUN);
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) cyc("drain", 0, 0, 1, 0, 0, S_DRAIN);
      for (int i = 0; i < 100; i++) begin
         set_in(i[3], 5'd4, 5'd4, 0, i[0], i[2], i[1], i[0]);
         cyc("halted_hold", 0, 0, 1, 0, 1, S_HALT);
      end
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      reset = 1'b1; cyc("halted_in_reset", 0, 0, 1, 0, 1, S_HALT);
      reset = 1'b0; cyc("after_halt_reset", 1, 1, 0, 0, 0, S_RUN);

      // Reset on the second drain cycle
      set_in(0, 0, 0, 0, 0, 1, 0, 0); cyc("s5_accept", 0, 0, 0, 0, 0, S_RUN);
      set_in(0, 0, 0, 0, 0, 0, 0, 0); cyc("s5_drain1", 0, 0, 1, 0, 0, S_DRAIN);
      reset = 1'b1;                   cyc("s5_drain2", 0, 0, 1, 0, 0, S_DRAIN);
      reset = 1'b0;                   cyc("s5_run",    1, 1, 0, 0, 0, S_RUN);
      cyc("s5_no_residue", 1, 1, 0, 0, 0, S_RUN);

      // Single-step mode
      set_in(0, 0, 0, 0, 0, 0, 0, 1); cyc("step_ignored_run", 1, 1, 0, 0, 0, S_RUN);
      set_in(0, 0, 0, 0, 0, 0, 1, 0); cyc("enter_step", 1, 1, 0, 0, 0, S_RUN);
      for (int i = 0; i < 10; i++) begin
         set_in(i[0], 5'd7, 5'd7, 0, 0, 0, 1, 0);
         cyc("step_wait_idle", 0, 0, 0, 0, 0, S_SW);
      end
      set_in(0, 0, 0, 0, 0, 0, 1, 1); cyc("step_pulse",     0, 0, 0, 0, 0, S_SW);
      set_in(0, 0, 0, 0, 0, 0, 1, 0); cyc("step_go",        1, 1, 0, 0, 0, S_SG);
      cyc("step_back_wait", 0, 0, 0, 0, 0, S_SW);
      set_in(0, 0, 0, 0, 0, 0, 1, 1); cyc("step_pulse2",    0, 0, 0, 0, 0, S_SW);
      set_in(1, 9, 9, 0, 0, 0, 1, 0); cyc("step_go_hazard", 0, 0, 1, 0, 0, S_SG);
      cyc("step_consumed", 0, 0, 0, 0, 0, S_SW);
      set_in(0, 0, 0, 0, 0, 0, 1, 1); cyc("step_pulse3",    0, 0, 0, 0, 0, S_SW);
      set_in(0, 0, 0, 0, 0, 0, 1, 0); cyc("step_go_retry",  1, 1, 0, 0, 0, S_SG);
      set_in(0, 0, 0, 0, 0, 0, 0, 0); cyc("step_mode_off",  0, 0, 0, 0, 0, S_SW);
      cyc("run_after_step", 1, 1, 0, 0, 0, S_RUN);
      set_in(0, 0, 0, 0, 0, 0, 1, 0); cyc("reenter_step",   1, 1, 0, 0, 0, S_RUN);
      set_in(0, 0, 0, 0, 0, 0, 1, 1); cyc("step_pulse4",    0, 0, 0, 0, 0, S_SW);
      set_in(0, 0, 0, 0, 0, 1, 1, 0); cyc("step_go_halt",   0, 0, 0, 0, 0, S_SG);
      set_in(0, 0, 0, 0, 0, 0, 1, 0); cyc("step_drain1",    0, 0, 1, 0, 0, S_DRAIN);
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      reset = 1'b1;                   cyc("step_drain2",    0, 0, 1, 0, 0, S_DRAIN);
      reset = 1'b0;                   cyc("step_reset_run", 1, 1, 0, 0, 0, S_RUN);

`ifdef HAZARD_STALL_CNT_EN
      reset = 1'b1; cyc("cnt_reset", 1, 1, 0, 0, 0, S_RUN);
      reset = 1'b0;
      check("stall_count_cleared", stall_count, 16'd0);
      set_in(1, 2, 2, 0, 0, 0, 0, 0);
      repeat (4) cyc("cnt_stall", 0, 0, 1, 0, 0, S_RUN);
      set_in(0, 0, 0, 0, 0, 0, 0, 0); cyc("cnt_run", 1, 1, 0, 0, 0, S_RUN);
      check("stall_count_4", stall_count, 16'd4);
      reset = 1'b1; cyc("cnt_reset2", 1, 1, 0, 0, 0, S_RUN);
      reset = 1'b0;
      check("stall_count_reset", stall_count, 16'd0);
`endif

      check("scoreboard_empty", 16'(exp_q.size()), 16'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
